// File: rtl/ex3_frame_packer_if.sv
// Handshake bundle between the Excess-3 converter, the frame packer and
// the downstream formatter. The master drives digits and takes frames;
// the slave (the packer) accepts digits and presents frames.
interface ex3_frame_packer_if #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
);
  localparam int CW = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            ex;
  logic                  error;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [CW-1:0]         out_count;
  logic                  out_err;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output in_valid, ex, error, flush, out_ready,
    input  in_ready, out_valid, out_bcd, out_count, out_err, err_cnt
  );

  modport slave (
    input  in_valid, ex, error, flush, out_ready,
    output in_ready, out_valid, out_bcd, out_count, out_err, err_cnt
  );
endinterface

// File: rtl/ex3_frame_packer.sv
// Excess-3 to BCD frame packer. Converts each accepted Excess-3 digit to
// BCD, shifts it into a frame (first digit ends up most significant), and
// presents full or flushed partial frames on a valid/ready handshake.
// Bad digits are stored as zero, flag the frame and bump a saturating
// lifetime counter. The interface instance must use the same DIGITS and
// CNT_W as this module.
module ex3_frame_packer #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  ex3_frame_packer_if.slave  bus
);
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]          state;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] frame;
  logic                ferr;
  logic [CNT_W-1:0]    err_cnt_r;

  logic                acc;
  logic                bad;
  logic [3:0]          nib;
  logic                to_hold;
  logic                release_frame;

  // {bad, nibble}: a bad digit (upstream error or code outside 3..12) maps to 0
  function automatic logic [4:0] ex3_to_bcd(input logic [3:0] code, input logic err);
    if (err || (code < 4'd3) || (code > 4'd12))
      return {1'b1, 4'h0};
    else
      return {1'b0, code - 4'd3};
  endfunction

  // Lifetime counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Accept/transition decode; flush with an empty buffer and no accept is a no-op
  always_comb begin
    acc           = bus.in_valid && (state == COLLECT);
    {bad, nib}    = ex3_to_bcd(bus.ex, bus.error);
    to_hold       = (state == COLLECT) &&
                    ((acc && (cnt == CW'(DIGITS - 1))) ||
                     (bus.flush && ((cnt != '0) || acc)));
    release_frame = (state == HOLD) && bus.out_ready;
  end

  // FSM: COLLECT gathers digits, HOLD presents the frame until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= COLLECT;
    else if (to_hold)
      state <= HOLD;
    else if (release_frame)
      state <= COLLECT;
  end

  // Frame shift register, digit count and per-frame error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      cnt   <= '0;
      ferr  <= 1'b0;
    end else if (acc) begin
      frame <= {frame[4*DIGITS-5:0], nib};
      cnt   <= cnt + CW'(1);
      ferr  <= ferr | bad;
    end else if (release_frame) begin
      frame <= '0;
      cnt   <= '0;
      ferr  <= 1'b0;
    end
  end

  // Saturating lifetime bad-digit counter; only accepted digits count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_r <= '0;
    else if (acc && bad)
      err_cnt_r <= sat_inc(err_cnt_r);
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_bcd   = frame;
  assign bus.out_count = cnt;
  assign bus.out_err   = ferr;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ex3_frame_packer.sv
// Bench for ex3_frame_packer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based frame model.
module tb_ex3_frame_packer;
  localparam int DIGITS = 4;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex3_frame_packer_if #(.DIGITS(DIGITS), .CNT_W(CNT_W)) bus ();

  ex3_frame_packer #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                  q[$];
  bit                  mbad;
  bit                  mhold;
  logic [4*DIGITS-1:0] mbcd;
  int                  mcount;
  bit                  merr;
  int                  mec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mbad = 0; mhold = 0; mbcd = '0; mcount = 0; merr = 0; mec = 0;
  endtask

  // Frame value: digits in arrival order read as a base-16 number
  task automatic model_edge();
    bit good;
    if (!mhold) begin
      if (bus.in_valid) begin
        good = !bus.error && (bus.ex >= 3) && (bus.ex <= 12);
        q.push_back(good ? int'(bus.ex) - 3 : 0);
        if (!good) begin
          mbad = 1;
          mec++;
        end
      end
      if ((q.size() == DIGITS) || (bus.flush && q.size() > 0)) begin
        mhold  = 1;
        mbcd   = '0;
        foreach (q[i]) mbcd = (mbcd << 4) | (4*DIGITS)'(q[i]);
        mcount = q.size();
        merr   = mbad;
      end
    end else if (bus.out_ready) begin
      mhold = 0;
      q.delete();
      mbad = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    int ec;
    ec = (mec > CMAX) ? CMAX : mec;
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(!mhold));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(mhold));
    chk({tag, "_err_cnt"},   32'(bus.err_cnt),   32'(ec));
    if (mhold) begin
      chk({tag, "_out_bcd"},   32'(bus.out_bcd),   32'(mbcd));
      chk({tag, "_out_count"}, 32'(bus.out_count), 32'(mcount));
      chk({tag, "_out_err"},   32'(bus.out_err),   32'(merr));
    end
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge
  task automatic cycle(input bit v, input logic [3:0] e, input bit er, input bit f, input bit ordy);
    bus.in_valid  = v;
    bus.ex        = e;
    bus.error     = er;
    bus.flush     = f;
    bus.out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  initial begin
    logic [15:0] held;
    int guard;

    rst = 1'b1;
    bus.in_valid = 0; bus.ex = '0; bus.error = 0; bus.flush = 0; bus.out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bcd",   32'(bus.out_bcd),   32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    rst = 1'b0;

    // 1: clean full frame
    cycle(1, 4'h4, 0, 0, 1);
    cycle(1, 4'h8, 0, 0, 1);
    cycle(1, 4'hC, 0, 0, 1);
    chk("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    cycle(1, 4'h3, 0, 0, 1);
    chk("t1_valid",  32'(bus.out_valid), 32'd1);
    chk("t1_bcd",    32'(bus.out_bcd),   32'h1590);
    chk("t1_count",  32'(bus.out_count), 32'd4);
    chk("t1_err",    32'(bus.out_err),   32'd0);
    cycle(0, 4'h0, 0, 0, 1);
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);

    // 2: out-of-range code, then upstream error flag
    cycle(1, 4'h4, 0, 0, 0);
    cycle(1, 4'hD, 0, 0, 0);
    cycle(1, 4'h5, 0, 0, 0);
    cycle(1, 4'h6, 0, 0, 0);
    chk("t2a_bcd", 32'(bus.out_bcd), 32'h1023);
    chk("t2a_err", 32'(bus.out_err), 32'd1);
    chk("t2a_cnt", 32'(bus.err_cnt), 32'd1);
    cycle(0, 4'h0, 0, 0, 1);
    cycle(1, 4'h4, 0, 0, 0);
    cycle(1, 4'h7, 1, 0, 0);
    cycle(1, 4'h5, 0, 0, 0);
    cycle(1, 4'h6, 0, 0, 0);
    chk("t2b_bcd", 32'(bus.out_bcd), 32'h1023);
    chk("t2b_cnt", 32'(bus.err_cnt), 32'd2);
    cycle(0, 4'h0, 0, 0, 1);

    // 3: backpressure with extra (bad) digits offered while holding
    cycle(1, 4'h9, 0, 0, 0);
    cycle(1, 4'hA, 0, 0, 0);
    cycle(1, 4'hB, 0, 0, 0);
    cycle(1, 4'hC, 0, 0, 0);
    held = bus.out_bcd;
    chk("t3_bcd", 32'(held), 32'h6789);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 4'hF, 0, 0, 0);
      chk("t3_stable", 32'(bus.out_bcd), 32'h6789);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
    end
    chk("t3_no_count", 32'(bus.err_cnt), 32'd2);
    cycle(0, 4'h0, 0, 0, 1);
    chk("t3_release_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_release_ready", 32'(bus.in_ready),  32'd1);

    // 4: flush cases
    cycle(1, 4'h5, 0, 0, 0);
    cycle(1, 4'h6, 0, 0, 0);
    cycle(0, 4'h0, 0, 1, 0);
    chk("t4_bcd",   32'(bus.out_bcd),   32'h0023);
    chk("t4_count", 32'(bus.out_count), 32'd2);
    cycle(0, 4'h0, 0, 0, 1);
    cycle(0, 4'h0, 0, 1, 1);
    chk("t4_empty_flush", 32'(bus.out_valid), 32'd0);
    cycle(1, 4'h3, 0, 0, 0);
    cycle(1, 4'h4, 0, 0, 0);
    cycle(1, 4'h5, 0, 0, 0);
    cycle(1, 4'h6, 0, 1, 0);
    chk("t4_full_bcd",   32'(bus.out_bcd),   32'h0123);
    chk("t4_full_count", 32'(bus.out_count), 32'd4);
    cycle(0, 4'h0, 0, 1, 1);
    chk("t4_hold_flush", 32'(bus.out_valid), 32'd0);
    cycle(0, 4'h0, 0, 0, 0);
    chk("t4_hold_flush_idle", 32'(bus.out_valid), 32'd0);

    // 5: asynchronous reset mid-frame
    cycle(1, 4'h7, 1, 0, 0);
    cycle(1, 4'h8, 0, 0, 0);
    cycle(1, 4'h9, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_out_bcd",   32'(bus.out_bcd),   32'd0);
    chk("t5_out_count", 32'(bus.out_count), 32'd0);
    chk("t5_err_cnt",   32'(bus.err_cnt),   32'd0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    model_reset();
    bus.in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 4'h0, 0, 0, 0);
    chk("t5_no_frame", 32'(bus.out_valid), 32'd0);
    cycle(1, 4'hB, 0, 0, 0);
    cycle(1, 4'hA, 0, 0, 0);
    cycle(1, 4'h9, 0, 0, 0);
    cycle(1, 4'h8, 0, 0, 0);
    chk("t5_bcd", 32'(bus.out_bcd), 32'h8765);
    chk("t5_err", 32'(bus.out_err), 32'd0);
    cycle(0, 4'h0, 0, 0, 1);

    // 6: saturation of the lifetime counter
    guard = 0;
    while (mec < 300 && guard < 2000) begin
      cycle(1, 4'hF, 0, 0, 1);
      guard++;
    end
    chk("t6_reached", 32'(mec >= 300), 32'd1);
    chk("t6_sat", 32'(bus.err_cnt), 32'hFF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
